// File: rtl/id_ex_pipe_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the ID/EX pipeline register slice.
//   ALUOP_*      : 2-bit ALU op encodings produced by the main decoder
//   FUNCT_W      : width of the instruction function field
//   REG_ADDR_W   : register index width
//   id_ex_ctrl_t : control bundle carried from decode into execute
//   CTRL_BUBBLE  : control bundle of an inserted bubble (all zero)
//   ld_action_e  : what the EX-side registers do on the next clock edge
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam int FUNCT_W    = 6;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic               alu_src;
    logic [1:0]         alu_op;
    logic [FUNCT_W-1:0] funct;
  } id_ex_ctrl_t;

  // A bubble must look like an add that writes nothing and touches no memory.
  localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    LOAD_BUBBLE = 2'b00,
    LOAD_HOLD   = 2'b01,
    LOAD_ID     = 2'b10
  } ld_action_e;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg_if
// Bundle of every signal crossing the ID/EX register apart from clk/rst_n.
//   master modport : decode/execute side (drives id_*, flush, ex_hold;
//                    observes id_stall and ex_*)
//   slave modport  : the pipeline register itself
// Optional macro ID_EX_BUBBLE_CNT_EN adds the bubble_cnt[15:0] signal.
// ---------------------------------------------------------------------------
interface id_ex_pipe_reg_if #(
  parameter int DW   = 32,
  parameter int RA_W = 5
);

  logic            id_valid;
  logic [1:0]      id_alu_op;
  logic [5:0]      id_funct;
  logic [DW-1:0]   id_rs_data;
  logic [DW-1:0]   id_rt_data;
  logic [DW-1:0]   id_imm;
  logic [RA_W-1:0] id_rs_addr;
  logic [RA_W-1:0] id_rt_addr;
  logic [RA_W-1:0] id_rd_addr;
  logic            id_reg_write;
  logic            id_mem_read;
  logic            id_mem_write;
  logic            id_alu_src;
  logic            flush;
  logic            ex_hold;

  logic            id_stall;
  logic            ex_valid;
  logic [1:0]      ex_alu_op;
  logic [5:0]      ex_funct;
  logic [DW-1:0]   ex_rs_data;
  logic [DW-1:0]   ex_rt_data;
  logic [DW-1:0]   ex_imm;
  logic [RA_W-1:0] ex_rs_addr;
  logic [RA_W-1:0] ex_rt_addr;
  logic [RA_W-1:0] ex_rd_addr;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            ex_mem_write;
  logic            ex_alu_src;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0]     bubble_cnt;
`endif

  modport master (
`ifdef ID_EX_BUBBLE_CNT_EN
    input  bubble_cnt,
`endif
    output id_valid, id_alu_op, id_funct, id_rs_data, id_rt_data, id_imm,
    output id_rs_addr, id_rt_addr, id_rd_addr,
    output id_reg_write, id_mem_read, id_mem_write, id_alu_src,
    output flush, ex_hold,
    input  id_stall, ex_valid, ex_alu_op, ex_funct,
    input  ex_rs_data, ex_rt_data, ex_imm,
    input  ex_rs_addr, ex_rt_addr, ex_rd_addr,
    input  ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src
  );

  modport slave (
`ifdef ID_EX_BUBBLE_CNT_EN
    output bubble_cnt,
`endif
    input  id_valid, id_alu_op, id_funct, id_rs_data, id_rt_data, id_imm,
    input  id_rs_addr, id_rt_addr, id_rd_addr,
    input  id_reg_write, id_mem_read, id_mem_write, id_alu_src,
    input  flush, ex_hold,
    output id_stall, ex_valid, ex_alu_op, ex_funct,
    output ex_rs_data, ex_rt_data, ex_imm,
    output ex_rs_addr, ex_rt_addr, ex_rd_addr,
    output ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src
  );

endinterface

// File: rtl/id_ex_pipe_reg_load_use_detect.sv
// ---------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard check between the load sitting in EX
// and the instruction waiting in ID.
//   ex_valid, ex_mem_read, ex_rd_addr : EX-side instruction
//   id_valid, id_rs_addr, id_rt_addr  : ID-side instruction
//   load_use                          : 1 = ID needs a loaded value not yet ready
// ---------------------------------------------------------------------------
module load_use_detect #(
  parameter int RA_W = 5
) (
  input  logic            ex_valid,
  input  logic            ex_mem_read,
  input  logic [RA_W-1:0] ex_rd_addr,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs_addr,
  input  logic [RA_W-1:0] id_rt_addr,
  output logic            load_use
);

  // rt is compared even for instructions that take an immediate operand B;
  // an occasional needless stall is cheaper than decoding operand usage here.
  // Register 0 is hard-wired, so a load into it never creates a dependency.
  always_comb begin
    load_use = ex_valid & ex_mem_read & (ex_rd_addr != '0) & id_valid &
               ((ex_rd_addr == id_rs_addr) | (ex_rd_addr == id_rt_addr));
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
// Decode-to-execute pipeline register. Latches operands, register indices and
// control (ALU op and funct pass through unchanged), inserts a one-cycle
// bubble on a load-use hazard and back-pressures fetch/decode via id_stall.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset (all ex_* outputs forced to 0)
//   bus   : id_ex_pipe_reg_if slave modport (id_* in, flush, ex_hold in,
//           id_stall and ex_* out)
// Optional macro ID_EX_BUBBLE_CNT_EN: adds a saturating 16-bit count of
// load-use bubbles on bus.bubble_cnt.
// ---------------------------------------------------------------------------
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int DW   = 32,
  parameter int RA_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  id_ex_pipe_reg_if.slave   bus
);

  logic            valid_q;
  id_ex_ctrl_t     ctrl_q;
  id_ex_ctrl_t     id_ctrl;
  logic [DW-1:0]   rs_data_q;
  logic [DW-1:0]   rt_data_q;
  logic [DW-1:0]   imm_q;
  logic [RA_W-1:0] rs_addr_q;
  logic [RA_W-1:0] rt_addr_q;
  logic [RA_W-1:0] rd_addr_q;
  logic            load_use;
  ld_action_e      action;

  load_use_detect #(.RA_W(RA_W)) u_load_use_detect (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rd_addr  (rd_addr_q),
    .id_valid    (bus.id_valid),
    .id_rs_addr  (bus.id_rs_addr),
    .id_rt_addr  (bus.id_rt_addr),
    .load_use    (load_use)
  );

  always_comb begin
    id_ctrl           = CTRL_BUBBLE;
    id_ctrl.reg_write = bus.id_reg_write;
    id_ctrl.mem_read  = bus.id_mem_read;
    id_ctrl.mem_write = bus.id_mem_write;
    id_ctrl.alu_src   = bus.id_alu_src;
    id_ctrl.alu_op    = bus.id_alu_op;
    id_ctrl.funct     = bus.id_funct;
  end

  // Edge priority: flush squashes everything, then a held EX freezes the
  // register, then a hazard or an empty decode slot yields a bubble.
  always_comb begin
    action = LOAD_ID;
    if (bus.flush) begin
      action = LOAD_BUBBLE;
    end else if (bus.ex_hold) begin
      action = LOAD_HOLD;
    end else if (load_use || !bus.id_valid) begin
      action = LOAD_BUBBLE;
    end
  end

  // A flush makes whatever sits in decode irrelevant, so it never stalls.
  assign bus.id_stall = ~bus.flush & (load_use | bus.ex_hold);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      ctrl_q    <= CTRL_BUBBLE;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
    end else begin
      case (action)
        LOAD_BUBBLE: begin
          valid_q   <= 1'b0;
          ctrl_q    <= CTRL_BUBBLE;
          rs_data_q <= '0;
          rt_data_q <= '0;
          imm_q     <= '0;
          rs_addr_q <= '0;
          rt_addr_q <= '0;
          rd_addr_q <= '0;
        end
        LOAD_ID: begin
          valid_q   <= 1'b1;
          ctrl_q    <= id_ctrl;
          rs_data_q <= bus.id_rs_data;
          rt_data_q <= bus.id_rt_data;
          imm_q     <= bus.id_imm;
          rs_addr_q <= bus.id_rs_addr;
          rt_addr_q <= bus.id_rt_addr;
          rd_addr_q <= bus.id_rd_addr;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ex_valid     = valid_q;
  assign bus.ex_alu_op    = ctrl_q.alu_op;
  assign bus.ex_funct     = ctrl_q.funct;
  assign bus.ex_reg_write = ctrl_q.reg_write;
  assign bus.ex_mem_read  = ctrl_q.mem_read;
  assign bus.ex_mem_write = ctrl_q.mem_write;
  assign bus.ex_alu_src   = ctrl_q.alu_src;
  assign bus.ex_rs_data   = rs_data_q;
  assign bus.ex_rt_data   = rt_data_q;
  assign bus.ex_imm       = imm_q;
  assign bus.ex_rs_addr   = rs_addr_q;
  assign bus.ex_rt_addr   = rt_addr_q;
  assign bus.ex_rd_addr   = rd_addr_q;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q;
  logic        lu_bubble;

  // Only hazard bubbles count; flush and hold take precedence over load_use.
  assign lu_bubble = ~bus.flush & ~bus.ex_hold & load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else if (lu_bubble && (bubble_cnt_q != 16'hFFFF)) begin
      bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign bus.bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipe_reg
// Directed self-checking bench for id_ex_pipe_reg. Inputs change on the
// falling edge, outputs are sampled on the falling edge after each rising one.
// Define ID_EX_BUBBLE_CNT_EN to also exercise the bubble counter.
// ---------------------------------------------------------------------------
module tb_id_ex_pipe_reg;
  import pipe_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  id_ex_pipe_reg_if #(.DW(32), .RA_W(5)) bus ();

  id_ex_pipe_reg #(.DW(32), .RA_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives a complete decode-stage instruction.
  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [5:0] fn,
                               input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic rw, input logic mr, input logic mw, input logic as);
    bus.id_valid     = v;
    bus.id_alu_op    = op;
    bus.id_funct     = fn;
    bus.id_rs_data   = rsd;
    bus.id_rt_data   = rtd;
    bus.id_imm       = imm;
    bus.id_rs_addr   = rs;
    bus.id_rt_addr   = rt;
    bus.id_rd_addr   = rd;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.id_mem_write = mw;
    bus.id_alu_src   = as;
  endtask

  task automatic apply_idle();
    applyStimulus(1'b0, 2'b00, 6'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.flush   = 1'b0;
    bus.ex_hold = 1'b0;
  endtask

  task automatic test_reset();
    apply_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0h expected 0", bus.ex_valid); end
    checks++; if ({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_alu_src, bus.ex_alu_op, bus.ex_funct} !== 12'h0) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %0h expected 0", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_alu_src, bus.ex_alu_op, bus.ex_funct}); end
    checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %0h expected 0", bus.id_stall); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_bubble: got %0h expected 0", bus.ex_valid); end
  endtask

  task automatic test_pass_through();
    applyStimulus(1'b1, ALUOP_RTYPE, 6'b100111, 32'h5, 32'h9, 32'h0, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL pt_valid: got %0h expected 1", bus.ex_valid); end
    checks++; if (bus.ex_alu_op !== 2'b10) begin errors++; $display("[TB] FAIL pt_alu_op: got %0h expected 2", bus.ex_alu_op); end
    checks++; if (bus.ex_funct !== 6'b100111) begin errors++; $display("[TB] FAIL pt_funct: got %0h expected 27", bus.ex_funct); end
    checks++; if (bus.ex_rs_data !== 32'h5) begin errors++; $display("[TB] FAIL pt_rs_data: got %0h expected 5", bus.ex_rs_data); end
    checks++; if ({bus.ex_rt_data, bus.ex_rd_addr, bus.ex_reg_write} !== {32'h9, 5'd4, 1'b1}) begin
      errors++; $display("[TB] FAIL pt_rt_rd_rw: got %0h expected %0h", {bus.ex_rt_data, bus.ex_rd_addr, bus.ex_reg_write}, {32'h9, 5'd4, 1'b1}); end
    // Asynchronous reset in the middle of a cycle.
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.ex_valid, bus.ex_alu_op, bus.ex_funct, bus.ex_rs_data, bus.ex_reg_write} !== 42'h0) begin
      errors++; $display("[TB] FAIL async_reset: got %0h expected 0", {bus.ex_valid, bus.ex_alu_op, bus.ex_funct, bus.ex_rs_data, bus.ex_reg_write}); end
    @(negedge clk);
    rst_n = 1'b1;
    apply_idle();
  endtask

  task automatic test_load_use();
    // lw r3 in EX, add using r3 in ID
    applyStimulus(1'b1, ALUOP_ADD, 6'd0, 32'h100, 32'h0, 32'h8, 5'd1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, ALUOP_RTYPE, 6'b100000, 32'h11, 32'h22, 32'h0, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.id_stall !== 1'b1) begin errors++; $display("[TB] FAIL lu_stall: got %0h expected 1", bus.id_stall); end
    tick();
    checks++; if ({bus.ex_valid, bus.ex_mem_read, bus.ex_rd_addr} !== 7'h0) begin
      errors++; $display("[TB] FAIL lu_bubble: got %0h expected 0", {bus.ex_valid, bus.ex_mem_read, bus.ex_rd_addr}); end
    checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("[TB] FAIL lu_stall_one_cycle: got %0h expected 0", bus.id_stall); end
    tick();
    checks++; if ({bus.ex_valid, bus.ex_rs_addr, bus.ex_rd_addr, bus.ex_rs_data} !== {1'b1, 5'd3, 5'd5, 32'h11}) begin
      errors++; $display("[TB] FAIL lu_resume: got %0h expected %0h", {bus.ex_valid, bus.ex_rs_addr, bus.ex_rd_addr, bus.ex_rs_data}, {1'b1, 5'd3, 5'd5, 32'h11}); end
    // Load into r0 never stalls.
    applyStimulus(1'b1, ALUOP_ADD, 6'd0, 32'h100, 32'h0, 32'h8, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, ALUOP_RTYPE, 6'b100000, 32'h33, 32'h44, 32'h0, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("[TB] FAIL lu_r0_stall: got %0h expected 0", bus.id_stall); end
    tick();
    checks++; if ({bus.ex_valid, bus.ex_rd_addr} !== {1'b1, 5'd6}) begin
      errors++; $display("[TB] FAIL lu_r0_load: got %0h expected %0h", {bus.ex_valid, bus.ex_rd_addr}, {1'b1, 5'd6}); end
    // Match on rt alone still stalls.
    applyStimulus(1'b1, ALUOP_ADD, 6'd0, 32'h100, 32'h0, 32'h8, 5'd1, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, ALUOP_IMM, 6'd0, 32'h1, 32'h2, 32'hFF, 5'd1, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (bus.id_stall !== 1'b1) begin errors++; $display("[TB] FAIL lu_rt_stall: got %0h expected 1", bus.id_stall); end
    tick();
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL lu_rt_bubble: got %0h expected 0", bus.ex_valid); end
    apply_idle();
    tick();
  endtask

  task automatic test_flush_priority();
    applyStimulus(1'b1, ALUOP_ADD, 6'd0, 32'h100, 32'h0, 32'h8, 5'd1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, ALUOP_RTYPE, 6'b100000, 32'h11, 32'h22, 32'h0, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.flush   = 1'b1;
    bus.ex_hold = 1'b1;
    #1;
    checks++; if (bus.id_stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_stall: got %0h expected 0", bus.id_stall); end
    tick();
    checks++; if ({bus.ex_valid, bus.ex_mem_read, bus.ex_reg_write, bus.ex_rs_data} !== 35'h0) begin
      errors++; $display("[TB] FAIL flush_bubble: got %0h expected 0", {bus.ex_valid, bus.ex_mem_read, bus.ex_reg_write, bus.ex_rs_data}); end
    apply_idle();
    tick();
  endtask

  task automatic test_hold();
    applyStimulus(1'b1, ALUOP_BR, 6'b100010, 32'hAAAA, 32'hBBBB, 32'h10, 5'd9, 5'd10, 5'd11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if ({bus.ex_valid, bus.ex_alu_op, bus.ex_funct} !== {1'b1, 2'b01, 6'b100010}) begin
      errors++; $display("[TB] FAIL hold_load_br: got %0h expected %0h", {bus.ex_valid, bus.ex_alu_op, bus.ex_funct}, {1'b1, 2'b01, 6'b100010}); end
    bus.ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, ALUOP_IMM, 6'(i + 1), 32'h1000 + 32'(i), 32'h0, 32'h0, 5'd12, 5'd13, 5'd14, 1'b1, 1'b0, 1'b1, 1'b1);
      #1;
      checks++; if (bus.id_stall !== 1'b1) begin errors++; $display("[TB] FAIL hold_stall_%0d: got %0h expected 1", i, bus.id_stall); end
      tick();
      checks++; if ({bus.ex_valid, bus.ex_alu_op, bus.ex_funct, bus.ex_rs_data, bus.ex_imm, bus.ex_rd_addr, bus.ex_mem_write}
                    !== {1'b1, 2'b01, 6'b100010, 32'hAAAA, 32'h10, 5'd11, 1'b0}) begin
        errors++; $display("[TB] FAIL hold_keep_%0d: got rs_data %0h funct %0h expected AAAA 22", i, bus.ex_rs_data, bus.ex_funct); end
    end
    bus.ex_hold = 1'b0;
    tick();
    checks++; if ({bus.ex_alu_op, bus.ex_funct, bus.ex_rs_data, bus.ex_mem_write, bus.ex_alu_src}
                  !== {2'b11, 6'd3, 32'h1002, 1'b1, 1'b1}) begin
      errors++; $display("[TB] FAIL hold_release: got rs_data %0h funct %0h expected 1002 3", bus.ex_rs_data, bus.ex_funct); end
  endtask

  task automatic test_invalid();
    applyStimulus(1'b0, ALUOP_RTYPE, 6'b100100, 32'h77, 32'h88, 32'h99, 5'd2, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    checks++; if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_alu_src} !== 5'h0) begin
      errors++; $display("[TB] FAIL invalid_ctrl: got %0h expected 0", {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_alu_src}); end
    checks++; if ({bus.ex_alu_op, bus.ex_funct, bus.ex_rs_data, bus.ex_imm, bus.ex_rd_addr} !== 77'h0) begin
      errors++; $display("[TB] FAIL invalid_fields: got funct %0h rs_data %0h expected 0 0", bus.ex_funct, bus.ex_rs_data); end
  endtask

  task automatic test_back_to_back();
    applyStimulus(1'b1, ALUOP_RTYPE, 6'b100101, 32'hDEAD0001, 32'h2, 32'h0, 5'd1, 5'd2, 5'd20, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if ({bus.ex_funct, bus.ex_rs_data, bus.ex_rd_addr} !== {6'b100101, 32'hDEAD0001, 5'd20}) begin
      errors++; $display("[TB] FAIL b2b_0: got %0h expected %0h", {bus.ex_funct, bus.ex_rs_data, bus.ex_rd_addr}, {6'b100101, 32'hDEAD0001, 5'd20}); end
    applyStimulus(1'b1, ALUOP_ADD, 6'd0, 32'h40, 32'h5, 32'hFFFFFFFC, 5'd21, 5'd22, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    checks++; if ({bus.ex_imm, bus.ex_mem_write, bus.ex_alu_src, bus.ex_rt_addr} !== {32'hFFFFFFFC, 1'b1, 1'b1, 5'd22}) begin
      errors++; $display("[TB] FAIL b2b_1: got %0h expected %0h", {bus.ex_imm, bus.ex_mem_write, bus.ex_alu_src, bus.ex_rt_addr}, {32'hFFFFFFFC, 1'b1, 1'b1, 5'd22}); end
    applyStimulus(1'b1, ALUOP_IMM, 6'b001101, 32'h3, 32'h4, 32'h00FF, 5'd23, 5'd24, 5'd25, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    checks++; if ({bus.ex_valid, bus.ex_alu_op, bus.ex_funct, bus.ex_rs_addr} !== {1'b1, 2'b11, 6'b001101, 5'd23}) begin
      errors++; $display("[TB] FAIL b2b_2: got %0h expected %0h", {bus.ex_valid, bus.ex_alu_op, bus.ex_funct, bus.ex_rs_addr}, {1'b1, 2'b11, 6'b001101, 5'd23}); end
    apply_idle();
    tick();
  endtask

`ifdef ID_EX_BUBBLE_CNT_EN
  task automatic lu_event(input logic do_flush);
    applyStimulus(1'b1, ALUOP_ADD, 6'd0, 32'h100, 32'h0, 32'h8, 5'd1, 5'd2, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b1, ALUOP_RTYPE, 6'b100000, 32'h1, 32'h2, 32'h0, 5'd2, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.flush = do_flush;
    tick();
    bus.flush = 1'b0;
    tick();
    apply_idle();
  endtask

  task automatic test_bubble_cnt();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (bus.bubble_cnt !== 16'd0) begin errors++; $display("[TB] FAIL cnt_reset: got %0h expected 0", bus.bubble_cnt); end
    for (int i = 0; i < 5; i++) lu_event(1'b0);
    for (int i = 0; i < 2; i++) lu_event(1'b1);
    checks++; if (bus.bubble_cnt !== 16'd5) begin errors++; $display("[TB] FAIL cnt_five: got %0h expected 5", bus.bubble_cnt); end
    force dut.bubble_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.bubble_cnt_q;
    lu_event(1'b0);
    checks++; if (bus.bubble_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL cnt_saturate: got %0h expected ffff", bus.bubble_cnt); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    test_reset();
    test_pass_through();
    test_load_use();
    test_flush_priority();
    test_hold();
    test_invalid();
    test_back_to_back();
`ifdef ID_EX_BUBBLE_CNT_EN
    test_bubble_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
Decode-to-execute pipeline register of the 5-stage core. It latches decoded operands, register addresses and control bits, including the 2-bit ALU op and 6-bit function code consumed by the execute-stage ALU control decode. It also detects load-use hazards, inserts a one-cycle bubble and back-pressures fetch/decode. It handles branch flush and downstream hold.

Parameters:
DW, 32, operand/immediate data width
RA_W, 5, register address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode stage holds a real instruction
id_alu_op  in  2  ALU op from main decoder (10 R-type, 11 imm-logic, 00 add, 01 branch)
id_funct  in  6  instruction function field
id_rs_data  in  DW  source operand A
id_rt_data  in  DW  source operand B
id_imm  in  DW  sign-extended immediate
id_rs_addr  in  RA_W  rs index
id_rt_addr  in  RA_W  rt index
id_rd_addr  in  RA_W  destination index
id_reg_write  in  1  writeback enable
id_mem_read  in  1  load
id_mem_write  in  1  store
id_alu_src  in  1  1 = immediate operand B
flush  in  1  branch/jump squash from EX
ex_hold  in  1  EX cannot accept a new instruction this cycle
id_stall  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid  out  1  EX stage holds a real instruction
ex_alu_op  out  2  registered id_alu_op
ex_funct  out  6  registered id_funct
ex_rs_data, ex_rt_data, ex_imm  out  DW each  registered operands
ex_rs_addr, ex_rt_addr, ex_rd_addr  out  RA_W each  registered indices
ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src  out  1 each  registered control

Behaviour:
- Single clock domain on clk. rst_n is asynchronous assert, synchronous deassert. While rst_n=0, all ex_* outputs are 0.
- Bubble: ex_valid, ex_reg_write, ex_mem_read, ex_mem_write and ex_alu_src are 0. ex_alu_op is 2'b00, ex_funct is 0. All data and address fields are 0.
- load_use = ex_valid & ex_mem_read & (ex_rd_addr != 0) & id_valid & (ex_rd_addr == id_rs_addr | ex_rd_addr == id_rt_addr). The rt comparison is always made, which is conservative.
- id_stall = ~flush & (load_use | ex_hold).
- Per-edge priority, highest first:
  - flush: load a bubble. flush wins over ex_hold and load_use.
  - ex_hold: all ex_* registers keep their value.
  - load_use: load a bubble; decode contents are held upstream by id_stall.
  - id_valid=0: load a bubble.
  - Otherwise load all id_* fields and set ex_valid=1.
- Latency is 1 cycle from ID to EX. A load-use stall lasts exactly 1 cycle, because after the bubble ex_mem_read=0.
- ex_alu_op and ex_funct pass through unmodified, with no re-encoding. Encoding 01 is carried as-is.
- A flush in the same cycle as load_use inserts one bubble and does not stall.
- Reset asserted mid-stall clears everything. The first cycle after reset is a bubble unless id_valid=1.

Optional Feature:
ID_EX_BUBBLE_CNT_EN
- Defined: adds output bubble_cnt [15:0]. It increments on every edge where a load-use bubble is inserted, saturates at 16'hFFFF, and resets to 0. It does not count flush bubbles.
- Undefined: the port and the counter are absent. Behaviour is otherwise identical.

Decomposition:
- pipe_pkg holds:
  - ALUOP_ADD=2'b00, ALUOP_BR=2'b01, ALUOP_RTYPE=2'b10, ALUOP_IMM=2'b11
  - FUNCT_W=6 and REG_ADDR_W=5
  - packed struct id_ex_ctrl_t {reg_write, mem_read, mem_write, alu_src, alu_op, funct}
  - constant CTRL_BUBBLE
- One combinational sub-module, load_use_detect, computes load_use from the EX-side and ID-side fields.

Test Plan:
1. Reset then pass-through: rst_n low mid-cycle clears all ex_* outputs immediately. Then id_valid=1, alu_op=10, funct=6'b100111, rs_data=32'h5 → next edge ex_valid=1, ex_alu_op=10, ex_funct=100111, ex_rs_data=5.
2. Load-use: EX has lw with rd=3. ID has add with rs=3 → id_stall=1 for one cycle and EX receives a bubble. The following edge loads the add and id_stall=0. Same case with rd=0 → no stall.
3. Flush priority: flush=1 together with ex_hold=1 and load_use=1 → next edge ex_valid=0, ex_mem_read=0, id_stall=0.
4. Hold: ex_hold=1 for 3 cycles while id_* fields change → ex_* outputs stay constant and id_stall=1 throughout. Release → new instruction loads.
5. id_valid=0 with id_reg_write=1 → bubble loaded and ex_reg_write=0.
6. With ID_EX_BUBBLE_CNT_EN defined: 5 load-use events and 2 flushes → bubble_cnt=5. Forced to 16'hFFFF, another event keeps it at 16'hFFFF.
